// File: rtl/morse_key_decoder.sv
// Single-key Morse front end: synchronise and debounce a raw active-low key,
// time presses into dots/dashes and group them into letters by a key-up timeout.
module morse_key_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned DASH_CYCLES     = 15000000,
    parameter int unsigned GAP_CYCLES      = 30000000,
    parameter int unsigned MAX_SYMBOLS     = 5,
    parameter int unsigned CNT_W           = 32,
    localparam int unsigned LEN_W          = $clog2(MAX_SYMBOLS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   button1,
    input  logic                   clear,
    output logic                   key_down,
    output logic                   element_valid,
    output logic                   element_is_dash,
    output logic [MAX_SYMBOLS-1:0] code_out,
    output logic [LEN_W-1:0]       code_len,
    output logic                   code_valid,
    output logic                   overflow
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_GAP,
        S_DRAIN
    } state_t;

    logic                   sync1_q;
    logic                   s_q;
    logic                   deb_q;
    logic [DB_W-1:0]        stab_q;
    logic [CNT_W-1:0]       dur_q;
    logic [CNT_W-1:0]       dur_d;
    logic [CNT_W-1:0]       gap_q;
    state_t                 state_q;
    logic [MAX_SYMBOLS-1:0] work_q;
    logic [MAX_SYMBOLS-1:0] work_d;
    logic [LEN_W-1:0]       elem_cnt_q;
    logic                   ovf_q;
    logic                   is_dash;

    // Synchronisers idle high so a key held through reset is seen as a fresh press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            s_q     <= 1'b1;
            deb_q   <= 1'b1;
            stab_q  <= '0;
        end else begin
            sync1_q <= button1;
            s_q     <= sync1_q;
            if (s_q == deb_q) begin
                stab_q <= '0;
            end else if (stab_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_q  <= s_q;
                stab_q <= '0;
            end else begin
                stab_q <= stab_q + DB_W'(1);
            end
        end
    end

    assign key_down = ~deb_q;

    always_comb begin
        dur_d = '0;
        if (key_down) begin
            dur_d = (dur_q == '1) ? dur_q : dur_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dur_q <= '0;
        end else begin
            dur_q <= dur_d;
        end
    end

    assign is_dash = (dur_q >= CNT_W'(DASH_CYCLES));

    // Element k lands at bit MAX_SYMBOLS-1-k so letters are left-aligned.
    always_comb begin
        work_d = work_q;
        for (int i = 0; i < int'(MAX_SYMBOLS); i++) begin
            if (LEN_W'(int'(MAX_SYMBOLS) - 1 - i) == elem_cnt_q) begin
                work_d[i] = is_dash;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            work_q          <= '0;
            elem_cnt_q      <= '0;
            ovf_q           <= 1'b0;
            gap_q           <= '0;
            element_valid   <= 1'b0;
            element_is_dash <= 1'b0;
            code_out        <= '0;
            code_len        <= '0;
            code_valid      <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            element_valid <= 1'b0;
            code_valid    <= 1'b0;
            if (clear) begin
                work_q     <= '0;
                elem_cnt_q <= '0;
                ovf_q      <= 1'b0;
                gap_q      <= '0;
                state_q    <= key_down ? S_DRAIN : S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (key_down) begin
                            state_q <= S_PRESS;
                        end
                    end
                    S_PRESS: begin
                        if (!key_down) begin
                            element_valid   <= 1'b1;
                            element_is_dash <= is_dash;
                            if (elem_cnt_q < LEN_W'(MAX_SYMBOLS)) begin
                                work_q     <= work_d;
                                elem_cnt_q <= elem_cnt_q + LEN_W'(1);
                            end else begin
                                ovf_q <= 1'b1;
                            end
                            gap_q   <= '0;
                            state_q <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (key_down) begin
                            state_q <= S_PRESS;
                        end else if (gap_q >= CNT_W'(GAP_CYCLES)) begin
                            code_out   <= work_q;
                            code_len   <= elem_cnt_q;
                            overflow   <= ovf_q;
                            code_valid <= 1'b1;
                            work_q     <= '0;
                            elem_cnt_q <= '0;
                            ovf_q      <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            gap_q <= gap_q + CNT_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (!key_down) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/morse_key_decoder.md
# morse_key_decoder

Parametrised successor to the single-button Morse front end. It takes one raw, active-low, bouncing key input and debounces it. It measures press and release durations in clock cycles, classifies each press as dot or dash, and groups elements into letters using a gap timeout. Each completed letter is emitted as a left-aligned element code, an element count and a one-cycle valid strobe, for consumption by a downstream character lookup or display block.

## Interface
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required before the debounced key level changes.
- DASH_CYCLES, 15000000: press duration (cycles) at or above which an element is a dash; below it is a dot.
- GAP_CYCLES, 30000000: key-up cycles that terminate a letter.
- MAX_SYMBOLS, 5: maximum elements per letter (≥1).
- CNT_W, 32: width of the duration and gap counters (must hold DASH_CYCLES and GAP_CYCLES).
- LEN_W, derived as $clog2(MAX_SYMBOLS+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous and active-low.
- button1  in  1  raw key, 0 = pressed; asynchronous to clk.
- clear  in  1  synchronous abort of the letter in progress.
- key_down  out  1  debounced key level, 1 = pressed.
- element_valid  out  1  one-cycle strobe per completed element.
- element_is_dash  out  1  class of the element; meaningful only with element_valid.
- code_out  out  MAX_SYMBOLS  letter code: element k (0-based) at bit MAX_SYMBOLS-1-k, 1 = dash; unused bits 0.
- code_len  out  LEN_W  number of elements stored in code_out.
- code_valid  out  1  one-cycle strobe per emitted letter.
- overflow  out  1  letter had more than MAX_SYMBOLS elements; updated with code_valid.

## Operation

**Synchroniser.** button1 passes through two flops to produce s.

**Debouncer.** Register deb resets to 1.
- While s == deb, the stability counter is 0.
- While s != deb, the counter increments.
- On the cycle the counter would reach DEBOUNCE_CYCLES, deb <= s and the counter clears.
- key_down = ~deb.

**Duration counter.**
- Counts cycles with key_down = 1 and saturates at 2^CNT_W-1.
- The first pressed cycle counts as 1.
- Classification: dash if duration ≥ DASH_CYCLES.

**State machine.**
- IDLE: key_down rises -> PRESS.
- PRESS: key_down falls -> classify the element.
  - If elem_cnt < MAX_SYMBOLS, store the element and increment elem_cnt.
  - Otherwise set the internal ovf flag and drop the element.
  - Pulse element_valid, clear the gap counter, go to GAP.
- GAP: gap counter counts key-up cycles.
  - key_down rises before GAP_CYCLES -> PRESS; the letter continues.
  - Count reaches GAP_CYCLES -> register code_out, code_len and overflow from the working values, pulse code_valid, clear the working code, elem_cnt and ovf, then go to IDLE.
- DRAIN: entered on clear while key_down = 1; waits for key_down = 0, then goes to IDLE. No element is produced.
- clear in any state:
  - Discards the working code, elem_cnt and ovf.
  - No code_valid is produced.
  - Next state is DRAIN if key_down = 1, else IDLE.
  - clear has priority over a simultaneous element completion or letter emit.
- code_out, code_len and overflow hold their last emitted values until the next code_valid.

**Reset.** Synchronous reset behaves as follows:
- All outputs go to 0; deb = 1; state = IDLE; all counters 0.
- A key held through reset is seen as a new press after DEBOUNCE_CYCLES. Its duration counts from that point.

## Timing
- button1 edge to key_down edge: 2 sync cycles + DEBOUNCE_CYCLES, for a clean edge. Both edges are delayed equally, so key_down high time equals the raw low time.
- Any bounce shorter than DEBOUNCE_CYCLES has no effect on key_down.
- element_valid is asserted one cycle after the first cycle with key_down = 0.
- code_valid is asserted on the cycle after the gap counter reaches GAP_CYCLES. The registered code, code_len and overflow are visible in that same cycle.
- element_valid and code_valid are never asserted in the same cycle.
- Throughput: one press is accepted per key-up/key-down pair. There is no backpressure; code_valid must be sampled when it pulses.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, DASH_CYCLES=20, GAP_CYCLES=40, MAX_SYMBOLS=5, CNT_W=16.

- **Reset:** rst_n low 3 cycles with button1=0 -> all outputs 0. After release, key_down=1 exactly 6 cycles later.
- **Glitch rejection:** button1 low 3 cycles, high 10, low 2, then high -> key_down, element_valid and code_valid stay 0.
- **Letter A:** button1 low 10, high 15, low 30, high 60 -> element_valid twice, with element_is_dash 0 then 1. Then one code_valid with code_out=01000, code_len=2, overflow=0.
- **Dash threshold:** press 19 cycles -> dot; press exactly 20 -> dash. Each press is followed by a 60-cycle release -> code_out=00000/len 1, then 10000/len 1.
- **Overflow:** six 5-cycle presses separated by 10-cycle gaps, then release -> code_valid once with code_len=5, code_out=00000, overflow=1. The next letter (one dash) gives overflow=0.
- **Clear:** after two dots, assert clear during the gap; then a 25-cycle press is asserted with clear held through it -> no code_valid, no element for the held press. A following 25-cycle press and release -> code_out=10000, code_len=1.
